// File: rtl/upcounter_cdc_latch_sched_if.sv
// Control/status bundle between the read-domain host logic and the counter-bank sequencer.
interface upcounter_cdc_latch_sched_if #(
  parameter int NUM_COUNTERS = 8,
  parameter int PERIOD_WIDTH = 24
);
  logic                    latch_req_i;
  logic                    reset_req_i;
  logic [NUM_COUNTERS-1:0] reset_mask_i;
  logic                    auto_en_i;
  logic [PERIOD_WIDTH-1:0] auto_period_i;
  logic [NUM_COUNTERS-1:0] mismatch_i;
  logic                    mismatch_clear_i;
  logic                    latch_counter_o;
  logic [NUM_COUNTERS-1:0] reset_counter_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    snapshot_valid_o;
  logic [NUM_COUNTERS-1:0] mismatch_sticky_o;
  logic                    mismatch_any_o;
  logic                    auto_overrun_o;

  modport master (
    output latch_req_i, reset_req_i, reset_mask_i, auto_en_i, auto_period_i,
           mismatch_i, mismatch_clear_i,
    input  latch_counter_o, reset_counter_o, busy_o, done_o, snapshot_valid_o,
           mismatch_sticky_o, mismatch_any_o, auto_overrun_o
  );

  modport slave (
    input  latch_req_i, reset_req_i, reset_mask_i, auto_en_i, auto_period_i,
           mismatch_i, mismatch_clear_i,
    output latch_counter_o, reset_counter_o, busy_o, done_o, snapshot_valid_o,
           mismatch_sticky_o, mismatch_any_o, auto_overrun_o
  );
endinterface

// File: rtl/upcounter_cdc_latch_sched.sv
// Read-domain sequencer for the CDC monitor counter bank: stretched latch/reset levels,
// settle wait, snapshot-valid flag, periodic auto-latch and sticky TMR mismatch status.
//
// state   | meaning
// S_IDLE  | no operation; dispatches pending/new requests (reset first)
// S_LATCH | latch level held high for PULSE_CYCLES
// S_RST   | per-counter reset level held for PULSE_CYCLES
// S_WAIT  | all levels low for SETTLE_CYCLES while values cross back
module upcounter_cdc_latch_sched #(
  parameter int NUM_COUNTERS  = 8,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int PERIOD_WIDTH  = 24
) (
  input logic                        clkread_i,
  input logic                        rst_clkread_i,
  upcounter_cdc_latch_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_RST, S_WAIT} state_t;

  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    pend_latch_q, pend_latch_d;
  logic [NUM_COUNTERS-1:0] pend_mask_q, pend_mask_d;
  logic                    op_latch_q, op_latch_d;
  logic                    latch_q;
  logic [NUM_COUNTERS-1:0] rst_lvl_q, rst_lvl_d;
  logic                    busy_q;
  logic                    done_q, done_d;
  logic                    snap_q, snap_d;
  logic [NUM_COUNTERS-1:0] sticky_q, sticky_d;
  logic                    any_q;
  logic                    overrun_q, overrun_d;
  logic [PERIOD_WIDTH-1:0] acnt_q, acnt_d;
  logic [PERIOD_WIDTH-1:0] aper_q, aper_d;
  logic [PERIOD_WIDTH-1:0] period_use;
  logic                    auto_run, auto_tick;
  logic [NUM_COUNTERS-1:0] new_mask, eff_mask;
  logic                    new_latch, eff_latch;
  logic                    timer_tc;

  // The live period is used while the count sits at zero, so a new period applies from the next wrap.
  always_comb begin
    auto_run   = bus.auto_en_i && (bus.auto_period_i != '0);
    period_use = (acnt_q == '0) ? bus.auto_period_i : aper_q;
    auto_tick  = auto_run && (acnt_q == period_use - PERIOD_WIDTH'(1));
    acnt_d     = '0;
    aper_d     = bus.auto_period_i;
    if (auto_run && !auto_tick) begin
      acnt_d = acnt_q + PERIOD_WIDTH'(1);
      aper_d = period_use;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pend_latch_d = pend_latch_q;
    pend_mask_d  = pend_mask_q;
    op_latch_d   = op_latch_q;
    rst_lvl_d    = rst_lvl_q;
    done_d       = 1'b0;
    snap_d       = snap_q;
    new_mask     = bus.reset_req_i ? bus.reset_mask_i : '0;
    new_latch    = bus.latch_req_i || auto_tick;
    eff_mask     = pend_mask_q | new_mask;
    eff_latch    = pend_latch_q || new_latch;
    timer_tc     = (timer_q == '0);
    sticky_d     = (bus.mismatch_clear_i ? '0 : sticky_q) | bus.mismatch_i;
    overrun_d    = (bus.mismatch_clear_i ? 1'b0 : overrun_q) || (auto_tick && pend_latch_q);

    case (state_q)
      S_IDLE: begin
        if (eff_mask != '0) begin
          state_d      = S_RST;
          timer_d      = PULSE_LOAD;
          rst_lvl_d    = eff_mask;
          pend_mask_d  = '0;
          pend_latch_d = eff_latch;
          op_latch_d   = 1'b0;
          snap_d       = 1'b0;
        end else if (eff_latch) begin
          state_d      = S_LATCH;
          timer_d      = PULSE_LOAD;
          pend_latch_d = 1'b0;
          op_latch_d   = 1'b1;
        end
      end
      S_LATCH, S_RST: begin
        pend_mask_d  = eff_mask;
        pend_latch_d = eff_latch;
        if (timer_tc) begin
          state_d   = S_WAIT;
          timer_d   = SETTLE_LOAD;
          rst_lvl_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAIT: begin
        pend_mask_d  = eff_mask;
        pend_latch_d = eff_latch;
        if (timer_tc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (op_latch_q) snap_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkread_i or posedge rst_clkread_i) begin
    if (rst_clkread_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pend_latch_q <= 1'b0;
      pend_mask_q  <= '0;
      op_latch_q   <= 1'b0;
      latch_q      <= 1'b0;
      rst_lvl_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      snap_q       <= 1'b0;
      sticky_q     <= '0;
      any_q        <= 1'b0;
      overrun_q    <= 1'b0;
      acnt_q       <= '0;
      aper_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_latch_q <= pend_latch_d;
      pend_mask_q  <= pend_mask_d;
      op_latch_q   <= op_latch_d;
      latch_q      <= (state_d == S_LATCH);
      rst_lvl_q    <= rst_lvl_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= done_d;
      snap_q       <= snap_d;
      sticky_q     <= sticky_d;
      any_q        <= |sticky_q;
      overrun_q    <= overrun_d;
      acnt_q       <= acnt_d;
      aper_q       <= aper_d;
    end
  end

  assign bus.latch_counter_o   = latch_q;
  assign bus.reset_counter_o   = rst_lvl_q;
  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.snapshot_valid_o  = snap_q;
  assign bus.mismatch_sticky_o = sticky_q;
  assign bus.mismatch_any_o    = any_q;
  assign bus.auto_overrun_o    = overrun_q;

endmodule

// File: tb/tb_upcounter_cdc_latch_sched.sv
// Bench for upcounter_cdc_latch_sched: timing-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_upcounter_cdc_latch_sched;
  localparam int N  = 8;
  localparam int P  = 4;
  localparam int S  = 8;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   tc = 0;

  upcounter_cdc_latch_sched_if #(.NUM_COUNTERS(N), .PERIOD_WIDTH(PW)) bus ();

  upcounter_cdc_latch_sched #(
    .NUM_COUNTERS(N), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .PERIOD_WIDTH(PW)
  ) dut (
    .clkread_i(clk),
    .rst_clkread_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: an operation dispatched in cycle c drives its level in c+1..c+P, is busy
  // through c+P+S and reports done in c+P+S+1, when the next op may be dispatched.
  int          mcyc = 0, op_kind = 0, op_c = 0, a_anchor = 0, a_per = 0, n = 0, t = 0;
  logic        a_active = 1'b0, run = 1'b0, tick = 1'b0, nl = 1'b0, el = 1'b0, free = 1'b0;
  logic        pend_latch = 1'b0;
  logic [N-1:0] pend_mask = '0, op_mask = '0, nm = '0, em = '0;
  logic        e_latch = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_snap = 1'b0;
  logic        e_any = 1'b0, e_ovr = 1'b0;
  logic [N-1:0] e_rst = '0, e_sticky = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcyc = 0; op_kind = 0; a_active = 1'b0; pend_latch = 1'b0; pend_mask = '0;
      e_latch = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_snap = 1'b0;
      e_any = 1'b0; e_ovr = 1'b0; e_rst = '0; e_sticky = '0;
    end else begin
      n = mcyc;
      run = bus.auto_en_i && (bus.auto_period_i != '0);
      tick = 1'b0;
      if (!run) a_active = 1'b0;
      else begin
        if (!a_active) begin
          a_active = 1'b1;
          a_anchor = n;
          a_per = int'(bus.auto_period_i);
        end
        if (n - a_anchor == a_per - 1) begin
          tick = 1'b1;
          a_active = 1'b0;
        end
      end
      nm = bus.reset_req_i ? bus.reset_mask_i : '0;
      nl = bus.latch_req_i || tick;
      e_ovr = (bus.mismatch_clear_i ? 1'b0 : e_ovr) || (tick && pend_latch);
      e_any = |e_sticky;
      e_sticky = (bus.mismatch_clear_i ? '0 : e_sticky) | bus.mismatch_i;
      free = (op_kind == 0) || (n >= op_c + P + S + 1);
      em = pend_mask | nm;
      el = pend_latch || nl;
      if (free) begin
        if (em != '0) begin
          op_kind = 2; op_c = n; op_mask = em; pend_mask = '0; pend_latch = el;
        end else if (el) begin
          op_kind = 1; op_c = n; pend_latch = 1'b0;
        end
      end else begin
        pend_mask = em;
        pend_latch = el;
      end
      t = n + 1;
      mcyc = t;
      e_latch = (op_kind == 1) && (t >= op_c + 1) && (t <= op_c + P);
      e_rst   = ((op_kind == 2) && (t >= op_c + 1) && (t <= op_c + P)) ? op_mask : '0;
      e_busy  = (op_kind != 0) && (t >= op_c + 1) && (t <= op_c + P + S);
      e_done  = (op_kind != 0) && (t == op_c + P + S + 1);
      if (op_kind == 2 && t == op_c + 1) e_snap = 1'b0;
      if (op_kind == 1 && t == op_c + P + S + 1) e_snap = 1'b1;
    end
  end

  always @(negedge clk) begin
    cmp("m_latch",  int'(bus.latch_counter_o),   int'(e_latch));
    cmp("m_rstlvl", int'(bus.reset_counter_o),   int'(e_rst));
    cmp("m_busy",   int'(bus.busy_o),            int'(e_busy));
    cmp("m_done",   int'(bus.done_o),            int'(e_done));
    cmp("m_snap",   int'(bus.snapshot_valid_o),  int'(e_snap));
    cmp("m_sticky", int'(bus.mismatch_sticky_o), int'(e_sticky));
    cmp("m_any",    int'(bus.mismatch_any_o),    int'(e_any));
    cmp("m_ovr",    int'(bus.auto_overrun_o),    int'(e_ovr));
    if (bus.latch_counter_o && bus.reset_counter_o != '0)
      cmp("excl", 1, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    tc++;
  endtask

  task automatic goto(input int target);
    while (tc < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.latch_req_i = 1'b0; bus.reset_req_i = 1'b0; bus.reset_mask_i = '0;
    bus.auto_en_i = 1'b0; bus.auto_period_i = '0; bus.mismatch_i = '0;
    bus.mismatch_clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", int'(bus.busy_o), 0);
    cmp("rst_latch", int'(bus.latch_counter_o), 0);
    rst = 1'b0;
    step();

    // single latch
    tc = 0;
    bus.latch_req_i = 1'b1;
    step(); bus.latch_req_i = 1'b0;
    cmp("t1_latch_c1", int'(bus.latch_counter_o), 1);
    goto(4);  cmp("t1_latch_c4", int'(bus.latch_counter_o), 1);
    goto(5);  cmp("t1_latch_c5", int'(bus.latch_counter_o), 0);
    cmp("t1_busy_c5", int'(bus.busy_o), 1);
    goto(12); cmp("t1_done_c12", int'(bus.done_o), 0);
    goto(13); cmp("t1_done_c13", int'(bus.done_o), 1);
    cmp("t1_snap_c13", int'(bus.snapshot_valid_o), 1);
    goto(14); cmp("t1_done_c14", int'(bus.done_o), 0);
    goto(20);

    // reset request arriving mid-latch is queued
    tc = 0;
    bus.latch_req_i = 1'b1;
    step(); bus.latch_req_i = 1'b0;
    goto(3); bus.reset_req_i = 1'b1; bus.reset_mask_i = 8'h05;
    step();  bus.reset_req_i = 1'b0; bus.reset_mask_i = '0;
    goto(13); cmp("t2_done_c13", int'(bus.done_o), 1);
    cmp("t2_snap_c13", int'(bus.snapshot_valid_o), 1);
    goto(14); cmp("t2_rst_c14", int'(bus.reset_counter_o), 8'h05);
    cmp("t2_snap_c14", int'(bus.snapshot_valid_o), 0);
    goto(17); cmp("t2_rst_c17", int'(bus.reset_counter_o), 8'h05);
    goto(18); cmp("t2_rst_c18", int'(bus.reset_counter_o), 0);
    goto(26); cmp("t2_done_c26", int'(bus.done_o), 1);
    goto(30);

    // simultaneous reset + latch: reset first; zero-mask reset ignored
    tc = 0;
    bus.latch_req_i = 1'b1; bus.reset_req_i = 1'b1; bus.reset_mask_i = 8'h01;
    step(); bus.latch_req_i = 1'b0; bus.reset_req_i = 1'b0; bus.reset_mask_i = '0;
    cmp("t3_rst_c1", int'(bus.reset_counter_o), 8'h01);
    cmp("t3_latch_c1", int'(bus.latch_counter_o), 0);
    goto(5); bus.reset_req_i = 1'b1;
    step();  bus.reset_req_i = 1'b0;
    goto(13); cmp("t3_done_c13", int'(bus.done_o), 1);
    goto(14); cmp("t3_latch_c14", int'(bus.latch_counter_o), 1);
    goto(26); cmp("t3_snap_c26", int'(bus.snapshot_valid_o), 1);
    goto(27); cmp("t3_busy_c27", int'(bus.busy_o), 0);
    goto(35);

    // auto latch, period 20 then 5
    tc = 0;
    bus.auto_en_i = 1'b1; bus.auto_period_i = 24'd20;
    goto(19); cmp("t4_latch_c19", int'(bus.latch_counter_o), 0);
    goto(20); cmp("t4_latch_c20", int'(bus.latch_counter_o), 1);
    goto(40); cmp("t4_latch_c40", int'(bus.latch_counter_o), 1);
    goto(45); bus.auto_period_i = 24'd5;
    goto(60); cmp("t4_latch_c60", int'(bus.latch_counter_o), 1);
    goto(69); cmp("t4_ovr_c69", int'(bus.auto_overrun_o), 0);
    goto(70); cmp("t4_ovr_c70", int'(bus.auto_overrun_o), 1);
    goto(72); cmp("t4_done_c72", int'(bus.done_o), 1);
    goto(73); cmp("t4_latch_c73", int'(bus.latch_counter_o), 1);
    goto(75); bus.auto_en_i = 1'b0;
    goto(110); cmp("t4_busy_c110", int'(bus.busy_o), 0);
    bus.mismatch_clear_i = 1'b1;
    step(); bus.mismatch_clear_i = 1'b0;
    cmp("t4_ovr_clr", int'(bus.auto_overrun_o), 0);

    // period 1 ticks every cycle
    tc = 0;
    bus.auto_en_i = 1'b1; bus.auto_period_i = 24'd1;
    goto(1); cmp("t4b_latch_c1", int'(bus.latch_counter_o), 1);
    goto(3); bus.auto_en_i = 1'b0; bus.auto_period_i = '0;
    goto(40);
    bus.mismatch_clear_i = 1'b1;
    step(); bus.mismatch_clear_i = 1'b0;

    // mismatch sticky
    tc = 0;
    bus.mismatch_i = 8'h08;
    step(); bus.mismatch_i = '0;
    cmp("t5_sticky_c1", int'(bus.mismatch_sticky_o), 8'h08);
    cmp("t5_any_c1", int'(bus.mismatch_any_o), 0);
    goto(2); cmp("t5_any_c2", int'(bus.mismatch_any_o), 1);
    goto(3); bus.mismatch_clear_i = 1'b1; bus.mismatch_i = 8'h08;
    step();  bus.mismatch_clear_i = 1'b0; bus.mismatch_i = '0;
    cmp("t5_sticky_c4", int'(bus.mismatch_sticky_o), 8'h08);
    goto(5); bus.mismatch_clear_i = 1'b1;
    step();  bus.mismatch_clear_i = 1'b0;
    cmp("t5_sticky_c6", int'(bus.mismatch_sticky_o), 0);
    goto(7); cmp("t5_any_c7", int'(bus.mismatch_any_o), 0);
    goto(8); bus.mismatch_i = 8'h21;
    step();  bus.mismatch_i = '0;
    goto(12);

    // async reset in the middle of a latch with a reset pending
    tc = 0;
    bus.latch_req_i = 1'b1;
    step(); bus.latch_req_i = 1'b0; bus.reset_req_i = 1'b1; bus.reset_mask_i = 8'h02;
    step(); bus.reset_req_i = 1'b0; bus.reset_mask_i = '0;
    cmp("t6_latch_c2", int'(bus.latch_counter_o), 1);
    #2 rst = 1'b1;
    #1;
    cmp("t6_latch_rst", int'(bus.latch_counter_o), 0);
    cmp("t6_busy_rst", int'(bus.busy_o), 0);
    cmp("t6_snap_rst", int'(bus.snapshot_valid_o), 0);
    cmp("t6_sticky_rst", int'(bus.mismatch_sticky_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tc = 0;
    goto(5);  cmp("t6_rstlvl_c5", int'(bus.reset_counter_o), 0);
    goto(30); cmp("t6_done_c30", int'(bus.done_o), 0);
    cmp("t6_busy_c30", int'(bus.busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
